molecule_scheduler: RTL and testbench
=====================================

# molecule_scheduler

Batch sequencer that feeds the molecular analysis path. It accepts one 1024-bit global challenge bundle (four 256-bit molecular structures) per handshake and dispatches the enabled slices one at a time, lowest index first, to the downstream analysis engine. Each dispatch is a valid/ready transfer followed by a wait for the engine's completion pulse, bounded by a timeout. It reports per-slice timeouts and a batch-complete pulse.

## Interface
- SLICE_W, 256, width of one molecular structure
- NUM_SLICES, 4, slices per challenge bundle (power of 2, ≥2)
- TIMEOUT, 1024, maximum cycles in WAIT per slice (≥2); timer width = clog2(TIMEOUT)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- global_challenges  in  SLICE_W*NUM_SLICES  bundle; slice i = bits [i*SLICE_W +: SLICE_W]
- challenge_valid  in  1  bundle offered
- slice_mask  in  NUM_SLICES  slices to dispatch, sampled with the bundle
- challenge_ready  out  1  high only in IDLE
- current_molecule  out  SLICE_W  slice being dispatched
- molecule_valid  out  1  dispatch request to the engine
- molecule_ready  in  1  engine accepts
- analysis_done  in  1  engine completion pulse
- slice_index  out  clog2(NUM_SLICES)  index of current_molecule
- batch_busy  out  1  high in every state except IDLE
- batch_done  out  1  one-cycle pulse at batch end
- timeout_flags  out  NUM_SLICES  bit i set if slice i timed out; valid from batch_done until the next accept

## Operation
- States: IDLE, SELECT, ISSUE, WAIT, FINISH.
- IDLE: challenge_ready=1. When challenge_valid=1, capture the bundle and slice_mask into internal registers, clear timeout_flags, and go to SELECT.
- SELECT: pick the lowest set bit of the pending mask. If one is found, load current_molecule and slice_index, then go to ISSUE. If the mask is empty, go to FINISH.
- ISSUE: molecule_valid=1. current_molecule and slice_index stay stable. On molecule_valid & molecule_ready, clear the timer and go to WAIT. molecule_valid never drops before the transfer.
- WAIT: molecule_valid=0 and the timer increments each cycle.
  - analysis_done=1: clear the pending bit, go to SELECT.
  - Timer = TIMEOUT-1 with no done: set timeout_flags[slice_index], clear the pending bit, go to SELECT.
  - Done and timeout in the same cycle: done wins and no flag is set.
- FINISH: batch_done=1 for one cycle, then go to IDLE.
- analysis_done outside WAIT is ignored. challenge_valid outside IDLE is ignored; the bundle is not captured.
- Captured bundle and mask do not change during a batch, regardless of input changes.
- Reset mid-batch (any state): immediately return to IDLE and drop the batch. No batch_done is produced.
- Reset values: state=IDLE, challenge_ready=1, and every other output 0 (current_molecule=0, slice_index=0, timeout_flags=0).

## Timing
- All outputs are registered except challenge_ready and batch_busy, which decode directly from state.
- Bundle accepted at cycle T, so SELECT at T+1 and molecule_valid at T+2.
- Transfer at cycle A, so WAIT runs from A+1.
- analysis_done at cycle D, so SELECT at D+1. The next molecule_valid is at D+2, or batch_done is at D+2 if nothing is pending.
- Timeout: the slice times out after exactly TIMEOUT cycles in WAIT without done. SELECT is one cycle later.
- Empty mask accepted at T gives batch_done at T+2.
- Back-to-back batches: IDLE at FINISH+1, so the next accept is possible at FINISH+1.
- Minimum per-slice overhead is 3 cycles (SELECT, ISSUE with ready=1, one WAIT cycle with immediate done).

## Test plan
- Mask 4'b1111, slice i = {64{i+1 as 4 bits}}, ready=1, done 3 cycles after each transfer:
  - molecule_valid at T+2 with slice_index 0..3 in order.
  - batch_done once, timeout_flags=0.
- Mask 4'b1010:
  - only slices 1 and 3 are dispatched, 1 first.
  - slice 0 and slice 2 are never presented.
- Hold molecule_ready=0 for 10 cycles in ISSUE:
  - molecule_valid and current_molecule stay constant.
  - WAIT starts only after ready rises.
- TIMEOUT=8, never assert done on slice 2 with mask 4'b0111:
  - slice 2 leaves WAIT after 8 cycles.
  - batch_done with timeout_flags=4'b0100.
  - Repeat with done exactly on cycle 8: flags=0.
- Mask 0: batch_done at T+2 and molecule_valid never rises.
  - Stray analysis_done and challenge_valid mid-batch have no effect.
- Assert reset low during WAIT of slice 1:
  - outputs are immediately at reset values and no batch_done.
  - After release, a new bundle starts at slice_index 0.

Source files
------------

// File: rtl/molecule_scheduler.sv
// Batch sequencer: captures a challenge bundle and dispatches enabled slices
// lowest-index first to the analysis engine, with a per-slice completion timeout.
module molecule_scheduler #(
  parameter int  SLICE_W    = 256,
  parameter int  NUM_SLICES = 4,
  parameter int  TIMEOUT    = 1024,
  localparam int IDX_W      = $clog2(NUM_SLICES),
  localparam int TMR_W      = $clog2(TIMEOUT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SLICE_W*NUM_SLICES-1:0] global_challenges,
  input  logic                          challenge_valid,
  input  logic [NUM_SLICES-1:0]         slice_mask,
  output logic                          challenge_ready,
  output logic [SLICE_W-1:0]            current_molecule,
  output logic                          molecule_valid,
  input  logic                          molecule_ready,
  input  logic                          analysis_done,
  output logic [IDX_W-1:0]              slice_index,
  output logic                          batch_busy,
  output logic                          batch_done,
  output logic [NUM_SLICES-1:0]         timeout_flags
);

  // state  | meaning
  // IDLE   | waiting for a bundle, challenge_ready high
  // SELECT | pick lowest pending slice, or finish when none left
  // ISSUE  | molecule_valid high until the engine accepts
  // WAIT   | wait for analysis_done, bounded by TIMEOUT cycles
  // FINISH | one-cycle batch_done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_FINISH
  } state_t;

  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  state_t                          state_q, state_d;
  logic [SLICE_W*NUM_SLICES-1:0]   bundle_q;
  logic [NUM_SLICES-1:0]           pending_q;
  logic [TMR_W-1:0]                timer_q;
  logic                            found;
  logic [IDX_W-1:0]                pick_idx;
  logic                            timer_end;

  assign challenge_ready = (state_q == S_IDLE);
  assign batch_busy      = (state_q != S_IDLE);
  assign timer_end       = (timer_q == TMR_MAX);

  // Descending scan so the lowest set bit is the one left standing.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int i = NUM_SLICES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        found    = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (challenge_valid) state_d = S_SELECT;
      S_SELECT: state_d = found ? S_ISSUE : S_FINISH;
      S_ISSUE:  if (molecule_ready) state_d = S_WAIT;
      S_WAIT:   if (analysis_done || timer_end) state_d = S_SELECT;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bundle_q         <= '0;
      pending_q        <= '0;
      timer_q          <= '0;
      current_molecule <= '0;
      slice_index      <= '0;
      molecule_valid   <= 1'b0;
      batch_done       <= 1'b0;
      timeout_flags    <= '0;
    end else begin
      molecule_valid <= (state_d == S_ISSUE);
      batch_done     <= (state_d == S_FINISH);
      case (state_q)
        S_IDLE: begin
          if (challenge_valid) begin
            bundle_q      <= global_challenges;
            pending_q     <= slice_mask;
            timeout_flags <= '0;
          end
        end
        S_SELECT: begin
          if (found) begin
            current_molecule <= bundle_q[pick_idx*SLICE_W +: SLICE_W];
            slice_index      <= pick_idx;
          end
        end
        S_ISSUE: begin
          if (molecule_ready) timer_q <= '0;
        end
        S_WAIT: begin
          // A done arriving on the last timer cycle still counts as success.
          if (analysis_done) begin
            pending_q[slice_index] <= 1'b0;
          end else if (timer_end) begin
            pending_q[slice_index]     <= 1'b0;
            timeout_flags[slice_index] <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_molecule_scheduler.sv
// Directed self-checking bench for molecule_scheduler (TIMEOUT=8), with a
// negedge monitor logging dispatches and a simple engine model issuing done.
module tb_molecule_scheduler;
  localparam int SW = 256;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam int BW = SW * NS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] global_challenges = '0;
  logic          challenge_valid = 1'b0;
  logic [NS-1:0] slice_mask = '0;
  logic          challenge_ready;
  logic [SW-1:0] current_molecule;
  logic          molecule_valid;
  logic          molecule_ready = 1'b1;
  logic          analysis_done;
  logic [1:0]    slice_index;
  logic          batch_busy;
  logic          batch_done;
  logic [NS-1:0] timeout_flags;

  logic eng_done = 1'b0;
  logic stray_done = 1'b0;
  assign analysis_done = eng_done | stray_done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  molecule_scheduler #(.SLICE_W(SW), .NUM_SLICES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .global_challenges(global_challenges), .challenge_valid(challenge_valid),
    .slice_mask(slice_mask), .challenge_ready(challenge_ready),
    .current_molecule(current_molecule), .molecule_valid(molecule_valid),
    .molecule_ready(molecule_ready), .analysis_done(analysis_done),
    .slice_index(slice_index), .batch_busy(batch_busy),
    .batch_done(batch_done), .timeout_flags(timeout_flags)
  );

  always #5 clk = ~clk;

  // Monitor and engine model; the only writer of the log variables.
  int            cyc = 0, n_log = 0, n_acc = 0, acc_cyc = 0;
  int            bd_cnt = 0, bd_cyc = 0, valid_cnt = 0, eng_cnt = 0;
  int            eng_delay = 3, eng_skip = -1;
  logic [NS-1:0] bd_flags = '0;
  int            pres_cnt [NS];
  int            log_idx [64];
  int            log_cyc [64];
  logic [SW-1:0] log_dat [64];

  initial for (int i = 0; i < NS; i++) pres_cnt[i] = 0;

  always @(negedge clk) begin
    cyc++;
    eng_done = 1'b0;
    if (!reset) eng_cnt = 0;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
    if (reset && molecule_valid) begin
      valid_cnt++;
      pres_cnt[slice_index]++;
    end
    if (reset && molecule_valid && molecule_ready) begin
      log_idx[n_log] = int'(slice_index);
      log_dat[n_log] = current_molecule;
      log_cyc[n_log] = cyc;
      n_log++;
      if (int'(slice_index) != eng_skip) eng_cnt = eng_delay;
    end
    if (reset && challenge_valid && challenge_ready) begin
      n_acc++;
      acc_cyc = cyc;
    end
    if (batch_done) begin
      bd_cnt++;
      bd_cyc = cyc;
      bd_flags = timeout_flags;
    end
  end

  function automatic logic [SW-1:0] slice_of(input int base, input int i);
    logic [3:0] n;
    n = 4'(base + i);
    return {64{n}};
  endfunction

  function automatic logic [BW-1:0] mk(input int base);
    logic [BW-1:0] r;
    for (int i = 0; i < NS; i++) r[i*SW +: SW] = slice_of(base, i);
    return r;
  endfunction

  task automatic accept(input logic [BW-1:0] b, input logic [NS-1:0] m);
    @(posedge clk); #1;
    global_challenges = b;
    slice_mask = m;
    challenge_valid = 1'b1;
    @(posedge clk); #1;
    challenge_valid = 1'b0;
  endtask

  task automatic wait_done(input int b0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (bd_cnt != b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    cmp_cnt++; if (challenge_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready: got %b exp 1", challenge_ready); end
    cmp_cnt++; if (batch_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b exp 0", batch_busy); end
    cmp_cnt++; if (molecule_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b exp 0", molecule_valid); end
    cmp_cnt++; if (batch_done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b exp 0", batch_done); end
    cmp_cnt++; if (slice_index !== 2'd0) begin err_cnt++; $display("FAIL rst_index: got %0d exp 0", slice_index); end
    cmp_cnt++; if (current_molecule !== '0) begin err_cnt++; $display("FAIL rst_molecule: got %h exp 0", current_molecule); end
    cmp_cnt++; if (timeout_flags !== 4'b0) begin err_cnt++; $display("FAIL rst_flags: got %b exp 0000", timeout_flags); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    cmp_cnt++; if (challenge_ready !== 1'b1) begin err_cnt++; $display("FAIL post_rst_ready: got %b exp 1", challenge_ready); end
  endtask

  task automatic test_full_mask();
    int l0, b0;
    bit ok;
    l0 = n_log; b0 = bd_cnt;
    eng_delay = 3; eng_skip = -1; molecule_ready = 1'b1;
    accept(mk(1), 4'b1111);
    wait_done(b0, ok);
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL full_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (n_log - l0 != 4) begin err_cnt++; $display("FAIL full_count: got %0d exp 4", n_log - l0); end
    for (int k = 0; k < 4; k++) begin
      cmp_cnt++; if (log_idx[l0+k] != k) begin err_cnt++; $display("FAIL full_index%0d: got %0d exp %0d", k, log_idx[l0+k], k); end
      cmp_cnt++; if (log_dat[l0+k] !== slice_of(1, k)) begin err_cnt++; $display("FAIL full_data%0d: got %h exp %h", k, log_dat[l0+k][15:0], slice_of(1, k)[15:0]); end
      cmp_cnt++; if (log_cyc[l0+k] - acc_cyc != 2 + 5*k) begin err_cnt++; $display("FAIL full_lat%0d: got %0d exp %0d", k, log_cyc[l0+k] - acc_cyc, 2 + 5*k); end
    end
    cmp_cnt++; if (bd_cnt - b0 != 1) begin err_cnt++; $display("FAIL full_done_cnt: got %0d exp 1", bd_cnt - b0); end
    cmp_cnt++; if (bd_cyc - acc_cyc != 22) begin err_cnt++; $display("FAIL full_done_lat: got %0d exp 22", bd_cyc - acc_cyc); end
    cmp_cnt++; if (bd_flags !== 4'b0000) begin err_cnt++; $display("FAIL full_flags: got %b exp 0000", bd_flags); end
  endtask

  task automatic test_sparse_mask();
    int l0, b0;
    int p0 [NS];
    bit ok;
    l0 = n_log; b0 = bd_cnt;
    for (int i = 0; i < NS; i++) p0[i] = pres_cnt[i];
    accept(mk(5), 4'b1010);
    wait_done(b0, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL sparse_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (n_log - l0 != 2) begin err_cnt++; $display("FAIL sparse_count: got %0d exp 2", n_log - l0); end
    cmp_cnt++; if (log_idx[l0] != 1) begin err_cnt++; $display("FAIL sparse_first: got %0d exp 1", log_idx[l0]); end
    cmp_cnt++; if (log_idx[l0+1] != 3) begin err_cnt++; $display("FAIL sparse_second: got %0d exp 3", log_idx[l0+1]); end
    cmp_cnt++; if (log_dat[l0+1] !== slice_of(5, 3)) begin err_cnt++; $display("FAIL sparse_data: got %h exp %h", log_dat[l0+1][15:0], slice_of(5, 3)[15:0]); end
    cmp_cnt++; if (pres_cnt[0] - p0[0] != 0) begin err_cnt++; $display("FAIL sparse_slice0: got %0d exp 0", pres_cnt[0] - p0[0]); end
    cmp_cnt++; if (pres_cnt[2] - p0[2] != 0) begin err_cnt++; $display("FAIL sparse_slice2: got %0d exp 0", pres_cnt[2] - p0[2]); end
    cmp_cnt++; if (bd_cyc - acc_cyc != 12) begin err_cnt++; $display("FAIL sparse_done_lat: got %0d exp 12", bd_cyc - acc_cyc); end
  endtask

  task automatic test_ready_hold();
    int l0, b0;
    bit ok;
    l0 = n_log; b0 = bd_cnt;
    molecule_ready = 1'b0;
    accept(mk(3), 4'b0001);
    @(negedge clk); #1;
    cmp_cnt++; if (molecule_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_select_valid: got %b exp 0", molecule_valid); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      cmp_cnt++; if (molecule_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_valid%0d: got %b exp 1", k, molecule_valid); end
      cmp_cnt++; if (current_molecule !== slice_of(3, 0)) begin err_cnt++; $display("FAIL hold_data%0d: got %h exp %h", k, current_molecule[15:0], slice_of(3, 0)[15:0]); end
    end
    @(posedge clk); #1;
    molecule_ready = 1'b1;
    wait_done(b0, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL hold_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (log_cyc[l0] - acc_cyc != 12) begin err_cnt++; $display("FAIL hold_xfer_lat: got %0d exp 12", log_cyc[l0] - acc_cyc); end
    cmp_cnt++; if (bd_cyc - acc_cyc != 17) begin err_cnt++; $display("FAIL hold_done_lat: got %0d exp 17", bd_cyc - acc_cyc); end
  endtask

  task automatic test_timeout();
    int l0, b0;
    bit ok;
    l0 = n_log; b0 = bd_cnt;
    eng_delay = 3; eng_skip = 2;
    accept(mk(1), 4'b0111);
    wait_done(b0, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL to_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (n_log - l0 != 3) begin err_cnt++; $display("FAIL to_count: got %0d exp 3", n_log - l0); end
    cmp_cnt++; if (bd_cyc - acc_cyc != 22) begin err_cnt++; $display("FAIL to_done_lat: got %0d exp 22", bd_cyc - acc_cyc); end
    cmp_cnt++; if (bd_flags !== 4'b0100) begin err_cnt++; $display("FAIL to_flags: got %b exp 0100", bd_flags); end
    cmp_cnt++; if (timeout_flags !== 4'b0100) begin err_cnt++; $display("FAIL to_flags_hold: got %b exp 0100", timeout_flags); end
    l0 = n_log; b0 = bd_cnt;
    eng_delay = 8; eng_skip = -1;
    accept(mk(1), 4'b0111);
    @(negedge clk); #1;
    cmp_cnt++; if (timeout_flags !== 4'b0000) begin err_cnt++; $display("FAIL edge_flags_clear: got %b exp 0000", timeout_flags); end
    wait_done(b0, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL edge_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (bd_cyc - acc_cyc != 32) begin err_cnt++; $display("FAIL edge_done_lat: got %0d exp 32", bd_cyc - acc_cyc); end
    cmp_cnt++; if (bd_flags !== 4'b0000) begin err_cnt++; $display("FAIL edge_flags: got %b exp 0000", bd_flags); end
    eng_delay = 3;
  endtask

  task automatic test_empty_mask();
    int v0, b0;
    bit ok;
    v0 = valid_cnt; b0 = bd_cnt;
    accept(mk(7), 4'b0000);
    wait_done(b0, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL empty_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (bd_cyc - acc_cyc != 2) begin err_cnt++; $display("FAIL empty_done_lat: got %0d exp 2", bd_cyc - acc_cyc); end
    cmp_cnt++; if (valid_cnt - v0 != 0) begin err_cnt++; $display("FAIL empty_valid: got %0d exp 0", valid_cnt - v0); end
  endtask

  task automatic test_stray_inputs();
    int l0, b0, a0;
    bit ok;
    l0 = n_log; b0 = bd_cnt; a0 = n_acc;
    molecule_ready = 1'b0;
    accept(mk(2), 4'b0001);
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    global_challenges = mk(12);
    slice_mask = 4'b1111;
    challenge_valid = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b1;
    challenge_valid = 1'b0;
    @(posedge clk); #1;
    stray_done = 1'b0;
    molecule_ready = 1'b1;
    wait_done(b0, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL stray_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (n_acc - a0 != 1) begin err_cnt++; $display("FAIL stray_accepts: got %0d exp 1", n_acc - a0); end
    cmp_cnt++; if (n_log - l0 != 1) begin err_cnt++; $display("FAIL stray_count: got %0d exp 1", n_log - l0); end
    cmp_cnt++; if (log_dat[l0] !== slice_of(2, 0)) begin err_cnt++; $display("FAIL stray_data: got %h exp %h", log_dat[l0][15:0], slice_of(2, 0)[15:0]); end
    cmp_cnt++; if (bd_cyc - acc_cyc != 9) begin err_cnt++; $display("FAIL stray_done_lat: got %0d exp 9", bd_cyc - acc_cyc); end
  endtask

  task automatic test_reset_mid_batch();
    int l0, b0;
    bit ok;
    l0 = n_log; b0 = bd_cnt;
    accept(mk(1), 4'b1111);
    repeat (8) @(posedge clk);
    #1;
    cmp_cnt++; if (n_log - l0 != 2) begin err_cnt++; $display("FAIL mid_progress: got %0d exp 2", n_log - l0); end
    reset = 1'b0;
    #1;
    cmp_cnt++; if (challenge_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_ready: got %b exp 1", challenge_ready); end
    cmp_cnt++; if (batch_busy !== 1'b0) begin err_cnt++; $display("FAIL mid_busy: got %b exp 0", batch_busy); end
    cmp_cnt++; if (slice_index !== 2'd0) begin err_cnt++; $display("FAIL mid_index: got %0d exp 0", slice_index); end
    cmp_cnt++; if (current_molecule !== '0) begin err_cnt++; $display("FAIL mid_molecule: got %h exp 0", current_molecule[15:0]); end
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    cmp_cnt++; if (bd_cnt - b0 != 0) begin err_cnt++; $display("FAIL mid_no_done: got %0d exp 0", bd_cnt - b0); end
    l0 = n_log;
    accept(mk(9), 4'b0001);
    wait_done(b0, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL after_timeout: got no batch_done exp batch_done"); end
    cmp_cnt++; if (log_idx[l0] != 0) begin err_cnt++; $display("FAIL after_index: got %0d exp 0", log_idx[l0]); end
    cmp_cnt++; if (log_dat[l0] !== slice_of(9, 0)) begin err_cnt++; $display("FAIL after_data: got %h exp %h", log_dat[l0][15:0], slice_of(9, 0)[15:0]); end
    cmp_cnt++; if (log_cyc[l0] - acc_cyc != 2) begin err_cnt++; $display("FAIL after_lat: got %0d exp 2", log_cyc[l0] - acc_cyc); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_ready_hold();
    test_timeout();
    test_empty_mask();
    test_stray_inputs();
    test_reset_mid_batch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
